// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WRITE,
        BREAK
    } rx_state_t;

    // Number of clk cycles per serial bit.
    function automatic logic [31:0] baud_cycles(input logic [31:0] freq, input logic [31:0] baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous rx line into the clk domain and
// produces the value used at each sample point.
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority vote;
// without it the synchronised line is used directly. Latency is the same.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rx_s,
    output logic sample
);

    logic sync_1;
    logic sync_2;

    // Two-flop synchroniser; idles high so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

    assign rx_s = sync_2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] history;

    // Remember the two previous synchronised values for the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            history <= 2'b11;
        end else begin
            history <= {history[0], sync_2};
        end
    end

    // Majority of the current and two previous synchronised values.
    always_comb begin
        sample = (sync_2 & history[0]) | (sync_2 & history[1]) | (history[0] & history[1]);
    end
`else
    // Without voting the sample is simply the synchronised line.
    always_comb begin
        sample = sync_2;
    end
`endif

endmodule

// File: rtl/uart_receiver_controller.sv
// uart_receiver_controller: recovers start/data/stop frames from the rx line,
// writes good words to the RX FIFO and flags framing errors and overruns.
// Build option: UART_RX_MAJORITY_VOTE_EN (majority-vote sampling, see uart_rx_sampler).
module uart_receiver_controller
    import uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  full,
    output logic                  we,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam logic [31:0] ONE_CYCLE = baud_cycles(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [31:0] HALF      = ONE_CYCLE >> 1;
    localparam int          BIT_W     = (WORD_WIDTH > 32'd1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 32'd1);

    rx_state_t             state;
    rx_state_t             next_state;
    logic [31:0]           clocks;
    logic [BIT_W-1:0]      bit_count;
    logic [WORD_WIDTH-1:0] shift;
    logic                  rx_s;
    logic                  sample;
    logic                  half_hit;
    logic                  bit_hit;

    uart_rx_sampler sampler (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .rx_s   (rx_s),
        .sample (sample)
    );

    assign half_hit = (clocks == HALF - 32'd1);
    assign bit_hit  = (clocks == ONE_CYCLE - 32'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decisions, taken only at the sample points.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!rx_s) next_state = START;
            START: if (half_hit) next_state = sample ? IDLE : DATA;
            DATA:  if (bit_hit && (bit_count == LAST_BIT)) next_state = STOP;
            STOP: begin
                if (bit_hit) begin
                    if (!sample)   next_state = BREAK;
                    else if (full) next_state = IDLE;
                    else           next_state = WRITE;
                end
            end
            WRITE: next_state = IDLE;
            BREAK: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The FIFO strobe lasts exactly the single WRITE cycle.
    always_comb begin
        we = 1'b0;
        if (state == WRITE) we = 1'b1;
    end

    // Bit timing, data shifting, output word and the one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            clocks      <= 32'd0;
            bit_count   <= '0;
            shift       <= '0;
            dout        <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                START: begin
                    clocks <= half_hit ? 32'd0 : clocks + 32'd1;
                end
                DATA: begin
                    if (bit_hit) begin
                        clocks    <= 32'd0;
                        shift     <= {sample, shift[WORD_WIDTH-1:1]};
                        bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + 1'b1;
                    end else begin
                        clocks <= clocks + 32'd1;
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        clocks <= 32'd0;
                        if (!sample)   frame_error <= 1'b1;
                        else if (full) overrun     <= 1'b1;
                        else           dout        <= shift;
                    end else begin
                        clocks <= clocks + 32'd1;
                    end
                end
                default: begin
                    clocks    <= 32'd0;
                    bit_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// tb_uart_receiver_controller: drives serial frames into the receiver and
// checks every pulse and the held output word against a frame-level model.
module tb_uart_receiver_controller;

    localparam int BIT_CLOCKS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       full = 1'b0;
    logic       we;
    logic [7:0] dout;
    logic       frame_error;
    logic       overrun;

    uart_receiver_controller #(
        .CLOCK_FREQUENCY (32'd16),
        .BAUD_RATE       (32'd1),
        .WORD_WIDTH      (32'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .full        (full),
        .we          (we),
        .dout        (dout),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // kind: 0 = good word written, 1 = overrun, 2 = framing error
    typedef struct {
        int         kind;
        logic [7:0] word;
        int         start;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         we_count = 0;
    int         fe_count = 0;
    int         ov_count = 0;
    logic       rst_at_edge = 1'b1;
    logic [7:0] exp_dout = 8'h00;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected %0d..%0d at cycle %0d", name, actual, lo, hi, cyc);
        end
    endtask

    // Compare process: every frame outcome is predicted when the frame is sent.
    always @(negedge clk) begin
        int   kind;
        int   npulse;
        exp_t e;
        if (rst_at_edge) begin
            exp_dout = 8'h00;
            checkOutput("reset_we", int'(we), 0);
            checkOutput("reset_frame_error", int'(frame_error), 0);
            checkOutput("reset_overrun", int'(overrun), 0);
            checkOutput("reset_dout", int'(dout), 0);
        end else begin
            npulse = int'(we) + int'(frame_error) + int'(overrun);
            if (npulse > 1) begin
                checkOutput("exclusive_pulses", npulse, 1);
            end else if (npulse == 1) begin
                kind = we ? 0 : (overrun ? 1 : 2);
                if (we) we_count++;
                if (overrun) ov_count++;
                if (frame_error) fe_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pulse_kind", kind, e.kind);
                    checkRange("pulse_latency", cyc - e.start, 150, 156);
                    if (e.kind == 0) begin
                        checkOutput("dout_on_we", int'(dout), int'(e.word));
                        exp_dout = e.word;
                    end else begin
                        checkOutput("dout_held_on_error", int'(dout), int'(exp_dout));
                    end
                end
            end else begin
                checkOutput("dout_held", int'(dout), int'(exp_dout));
            end
        end
    end

    // Transmit one frame: start, 8 data bits LSB-first, stop bit.
    // With glitch set, each data bit is inverted for one cycle near its middle.
    task automatic applyStimulus(input logic [7:0] word, input logic stop_bit,
                                 input logic full_v, input logic glitch);
        exp_t       e;
        logic [9:0] frame;
        logic       v;
        frame  = {stop_bit, word, 1'b0};
        e.kind = !stop_bit ? 2 : (full_v ? 1 : 0);
        e.word = word;
        e.start = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CLOCKS; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) begin
                    full    = full_v;
                    e.start = cyc;
                    exp_q.push_back(e);
                end
                v = frame[b];
                if (glitch && b >= 1 && b <= 8 && c == 7) v = ~v;
                din = v;
            end
        end
    endtask

    task automatic idleLine(input int n);
        repeat (n) begin
            @(negedge clk);
            din = 1'b1;
        end
    endtask

    initial begin
        int         we0;
        int         fe0;
        int         ov0;
        logic [9:0] partial;
        logic       prev_bad;

        $display("[TB] start");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idleLine(10);

        // Case 1: good frame 0xA5
        we0 = we_count; fe0 = fe_count; ov0 = ov_count;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        idleLine(20);
        checkOutput("t1_we_count", we_count - we0, 1);
        checkOutput("t1_fe_count", fe_count - fe0, 0);
        checkOutput("t1_ov_count", ov_count - ov0, 0);
        checkOutput("t1_dout", int'(dout), 'hA5);
        checkOutput("t1_pending", exp_q.size(), 0);

        // Case 2: short low glitch is rejected
        we0 = we_count; fe0 = fe_count; ov0 = ov_count;
        repeat (3) begin
            @(negedge clk);
            din = 1'b0;
        end
        idleLine(30);
        checkOutput("t2_pulses", (we_count - we0) + (fe_count - fe0) + (ov_count - ov0), 0);

        // Case 3: bad stop bit then line held low
        we0 = we_count; fe0 = fe_count;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) begin
            @(negedge clk);
            din = 1'b0;
        end
        checkOutput("t3_fe_count", fe_count - fe0, 1);
        idleLine(30);
        checkOutput("t3_fe_after_break", fe_count - fe0, 1);
        checkOutput("t3_we_count", we_count - we0, 0);
        checkOutput("t3_pending", exp_q.size(), 0);

        // Case 4: FIFO full -> overrun, dout untouched
        we0 = we_count; ov0 = ov_count;
        applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
        idleLine(20);
        full = 1'b0;
        checkOutput("t4_ov_count", ov_count - ov0, 1);
        checkOutput("t4_we_count", we_count - we0, 0);
        checkOutput("t4_dout", int'(dout), 'hA5);

        // Case 5: back-to-back frames
        we0 = we_count;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        idleLine(20);
        checkOutput("t5_we_count", we_count - we0, 2);
        checkOutput("t5_dout", int'(dout), 'hFF);
        checkOutput("t5_pending", exp_q.size(), 0);

        // Case 6: reset in the middle of frame 0x55
        partial = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < BIT_CLOCKS; c++) begin
                @(negedge clk);
                din = partial[b];
            end
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idleLine(10);
        checkOutput("t6_dout_after_reset", int'(dout), 0);
        we0 = we_count;
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
        idleLine(20);
        checkOutput("t6_we_count", we_count - we0, 1);
        checkOutput("t6_dout", int'(dout), 'h12);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // Single-cycle glitches at each data sample point are voted out
        we0 = we_count;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        idleLine(20);
        checkOutput("glitch_we_count", we_count - we0, 1);
        checkOutput("glitch_dout", int'(dout), 'hA5);
`endif

        // Randomised frames: random data, stop bit, FIFO state and gaps
        prev_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            int         gap;
            logic [7:0] w;
            logic       sb;
            logic       fv;
            gap = int'($urandom_range(0, 12));
            if (prev_bad && gap < 4) gap = 4;
            idleLine(gap);
            w  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            fv = ($urandom_range(0, 3) == 0);
            applyStimulus(w, sb, fv, 1'b0);
            prev_bad = !sb;
        end
        idleLine(30);
        full = 1'b0;
        checkOutput("final_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
